// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard scancode bridge.
//   - bus register addresses
//   - bit positions inside the STATUS word
//   - scancode type
package kb_pkg;

  localparam logic KB_ADDR_DATA   = 1'b0;
  localparam logic KB_ADDR_STATUS = 1'b1;

  localparam int unsigned KB_ST_NEMPTY  = 0;
  localparam int unsigned KB_ST_FULL    = 1;
  localparam int unsigned KB_ST_OVF     = 2;
  localparam int unsigned KB_ST_CNT_LSB = 8;

  typedef logic [7:0] kb_scancode_t;

endpackage

// File: rtl/kb_sync_fifo.sv
// Generic single-clock FIFO of scancodes.
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   push, wdata  write request and data; a push into a full FIFO is taken only
//                if a pop happens in the same cycle
//   pop          read request; ignored while empty
//   rdata        head entry (combinational, valid while !empty)
//   full, empty  occupancy flags
//   count        number of stored entries
module kb_sync_fifo
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  kb_scancode_t wdata,
  input  logic         pop,
  output kb_scancode_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  kb_scancode_t  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/kb_scancode_fifo.sv
// Bridge between the PS/2 receiver and the CPU bus.
// Ports:
//   clk, rst     system clock, synchronous active-low reset
//   kb_data      scancode from the receiver (stable around kb_ready rise)
//   kb_ready     asynchronous strobe, one rising edge per scancode
//   keyboard_cs  bus chip select
//   rd           bus read strobe
//   addr         0 = DATA (pops a byte), 1 = STATUS
//   rdata        registered read data
//   irq          high while scancodes are pending
module kb_scancode_fifo
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  kb_scancode_t kb_data,
  input  logic         kb_ready,
  input  logic         keyboard_cs,
  input  logic         rd,
  input  logic         addr,
  output logic [31:0]  rdata,
  output logic         irq
);

  logic          ready_s1, ready_s2, ready_s3;
  logic          push_req, pop_req, rd_access, status_rd, overflow_set;
  logic          overflow_q, overflow_d;
  logic [31:0]   rdata_q, rdata_d, status_word;
  logic          irq_q;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  kb_scancode_t  fifo_head;

  // kb_data is not synchronised: it is held stable long after kb_ready rises.
  assign push_req     = ready_s2 & ~ready_s3;
  assign rd_access    = keyboard_cs & rd;
  assign pop_req      = rd_access & (addr == KB_ADDR_DATA) & ~fifo_empty;
  assign status_rd    = rd_access & (addr == KB_ADDR_STATUS);
  assign overflow_set = push_req & fifo_full & ~pop_req;

  kb_sync_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (kb_data),
    .pop   (pop_req),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                          = '0;
    status_word[KB_ST_NEMPTY]            = ~fifo_empty;
    status_word[KB_ST_FULL]              = fifo_full;
    status_word[KB_ST_OVF]               = overflow_q;
    status_word[KB_ST_CNT_LSB +: CW]     = fifo_count;
  end

  always_comb begin
    rdata_d    = rdata_q;
    overflow_d = overflow_q;
    if (rd_access) begin
      if (addr == KB_ADDR_DATA) begin
        rdata_d = pop_req ? {24'h0, fifo_head} : 32'h0;
      end else begin
        rdata_d = status_word;
      end
    end
    // A new overflow wins over the clear-on-read.
    if (status_rd)    overflow_d = 1'b0;
    if (overflow_set) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_s1   <= 1'b0;
      ready_s2   <= 1'b0;
      ready_s3   <= 1'b0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ready_s1   <= kb_ready;
      ready_s2   <= ready_s1;
      ready_s3   <= ready_s2;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      irq_q      <= (fifo_count != '0);
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_kb_scancode_fifo.sv
module tb_kb_scancode_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {OpPush, OpData, OpStatus} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  din;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ready = 1'b0;
  logic        keyboard_cs = 1'b0;
  logic        rd = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];
  logic       model_ovf = 1'b0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  kb_scancode_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_data     (kb_data),
    .kb_ready    (kb_ready),
    .keyboard_cs (keyboard_cs),
    .rd          (rd),
    .addr        (addr),
    .rdata       (rdata),
    .irq         (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s          = '0;
    s[0]       = (sb.size() != 0);
    s[1]       = (sb.size() == DEPTH);
    s[2]       = model_ovf;
    s[8 +: CW] = CW'(sb.size());
    return s;
  endfunction

  task automatic bus_read(input logic a, output logic [31:0] d);
    keyboard_cs = 1'b1;
    rd          = 1'b1;
    addr        = a;
    tick();
    keyboard_cs = 1'b0;
    rd          = 1'b0;
    addr        = 1'b0;
    d           = rdata;
  endtask

  task automatic read_data(input string name);
    logic [31:0] d, e;
    bus_read(1'b0, d);
    e = 32'h0;
    if (sb.size() != 0) e = {24'h0, sb.pop_front()};
    check(name, d, e);
  endtask

  task automatic read_status(input string name);
    logic [31:0] d, e;
    bus_read(1'b1, d);
    e         = model_status();
    model_ovf = 1'b0;
    check(name, d, e);
  endtask

  // Full strobe: 4 cycles high, 4 cycles low; the byte lands well inside.
  task automatic kb_push(input logic [7:0] b);
    kb_data  = b;
    kb_ready = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(b);
    else model_ovf = 1'b1;
    repeat (4) tick();
    kb_ready = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    vec_t        v;
    logic [31:0] d, e;

    // Reset state
    repeat (3) tick();
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    tick();
    read_status("rst_status");
    check("rst_irq_after", {31'h0, irq}, 32'h0);

    // Push latency: kb_ready raised just after edge N; irq high after edge N+4
    kb_data  = 8'h1C;
    kb_ready = 1'b1;
    sb.push_back(8'h1C);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("lat_irq_n%0d", k), {31'h0, irq}, {31'h0, (k == 4)});
    end
    kb_ready = 1'b0;
    repeat (4) tick();
    bus_read(1'b1, d);
    check("one_status", d, 32'h0000_0101);
    bus_read(1'b0, d);
    check("one_data", d, {24'h0, sb.pop_front()});
    check("one_data_const", d, 32'h0000_001C);
    check("one_irq_hold", {31'h0, irq}, 32'h1);
    tick();
    check("one_irq_drop", {31'h0, irq}, 32'h0);

    // Table: overflow fill, sticky overflow clear, in-order drain
    for (int i = 1; i <= 9; i++) begin
      v.op = OpPush; v.din = 8'(i); v.exp = 32'h0;
      vecs.push_back(v);
    end
    v.op = OpStatus; v.din = 8'h0; v.exp = 32'h0000_0807; vecs.push_back(v);
    v.op = OpStatus; v.din = 8'h0; v.exp = 32'h0000_0803; vecs.push_back(v);
    for (int i = 1; i <= 8; i++) begin
      v.op = OpData; v.din = 8'h0; v.exp = 32'(i);
      vecs.push_back(v);
    end
    v.op = OpStatus; v.din = 8'h0; v.exp = 32'h0; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      unique case (vecs[i].op)
        OpPush: kb_push(vecs[i].din);
        OpData: begin
          bus_read(1'b0, d);
          check($sformatf("vec%0d_data", i), d, vecs[i].exp);
          e = 32'h0;
          if (sb.size() != 0) e = {24'h0, sb.pop_front()};
          check($sformatf("vec%0d_sb", i), d, e);
        end
        default: begin
          bus_read(1'b1, d);
          e         = model_status();
          model_ovf = 1'b0;
          check($sformatf("vec%0d_status", i), d, vecs[i].exp);
          check($sformatf("vec%0d_model", i), d, e);
        end
      endcase
    end

    // Full FIFO: DATA read aligned with push_req (write edge N+3)
    for (int i = 0; i < 8; i++) kb_push(8'h11 + 8'(i));
    kb_data  = 8'h20;
    kb_ready = 1'b1;
    tick();
    tick();
    keyboard_cs = 1'b1;
    rd          = 1'b1;
    addr        = 1'b0;
    tick();
    keyboard_cs = 1'b0;
    rd          = 1'b0;
    check("align_pop", rdata, {24'h0, sb.pop_front()});
    sb.push_back(8'h20);
    tick();
    kb_ready = 1'b0;
    repeat (4) tick();
    bus_read(1'b1, d);
    check("align_status", d, 32'h0000_0803);
    for (int i = 0; i < 8; i++) read_data($sformatf("align_drain%0d", i));
    check("align_last", rdata, 32'h0000_0020);

    // Empty DATA read, then a normal push/pop
    read_data("empty_data");
    read_status("empty_status");
    kb_push(8'hAA);
    read_data("aa_data");
    check("aa_const", rdata, 32'h0000_00AA);

    // Reset with 3 entries buffered
    kb_push(8'h31);
    kb_push(8'h32);
    kb_push(8'h33);
    read_status("pre_rst_status");
    rst = 1'b0;
    tick();
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    sb.delete();
    model_ovf = 1'b0;
    tick();
    read_status("post_rst_status");
    read_data("post_rst_empty");
    kb_push(8'h44);
    read_data("post_rst_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
